// File: rtl/bmx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bmx_pkg
// Description : Shared types and widths for the AHB bus matrix slice.
// Revision    : 1.0 - initial release
// ============================================================================
package bmx_pkg;

  localparam int BMX_ADDR_W  = 32;
  localparam int BMX_MAST_W  = 4;
  localparam int BMX_TRANS_W = 2;
  localparam int BMX_SIZE_W  = 3;
  localparam int BMX_BURST_W = 3;
  localparam int BMX_PROT_W  = 4;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_e;

  // Flat width of the address/control bundle: addr, auser, trans, write,
  // size, burst, prot, master, mastlock.
  function automatic int bmx_ctrl_w(input int addr_w, input int mast_w);
    return 2 * addr_w + BMX_TRANS_W + 1 + BMX_SIZE_W + BMX_BURST_W
           + BMX_PROT_W + mast_w + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bmx_in_hold_reg.sv
`default_nettype none
// ============================================================================
// Module      : bmx_in_hold_reg
// Description : Load-enabled capture register for an address/control bundle.
// Revision    : 1.0 - initial release
// ============================================================================
module bmx_in_hold_reg #(
  parameter int WIDTH = 82
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bmx_in_stage.sv
`default_nettype none
// ============================================================================
// Module      : bmx_in_stage
// Description : Per-master input stage of the AHB bus matrix; holds a stalled
//               address phase and returns HREADYOUT/HRESP to the master.
//               Optional wait counter: define BMX_IN_STAGE_PEND_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module bmx_in_stage
  import bmx_pkg::*;
#(
  parameter int ADDR_W = BMX_ADDR_W,
  parameter int MAST_W = BMX_MAST_W
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic                   HSELS,
  input  logic [ADDR_W-1:0]      HADDRS,
  input  logic [ADDR_W-1:0]      HAUSERS,
  input  logic [BMX_TRANS_W-1:0] HTRANSS,
  input  logic                   HWRITES,
  input  logic [BMX_SIZE_W-1:0]  HSIZES,
  input  logic [BMX_BURST_W-1:0] HBURSTS,
  input  logic [BMX_PROT_W-1:0]  HPROTS,
  input  logic [MAST_W-1:0]      HMASTERS,
  input  logic                   HMASTLOCKS,
  input  logic                   HREADYS,
  output logic                   HREADYOUTS,
  output logic                   HRESPS,
  output logic                   sel_in,
  output logic [ADDR_W-1:0]      addr_in,
  output logic [ADDR_W-1:0]      auser_in,
  output logic [BMX_TRANS_W-1:0] trans_in,
  output logic                   write_in,
  output logic [BMX_SIZE_W-1:0]  size_in,
  output logic [BMX_BURST_W-1:0] burst_in,
  output logic [BMX_PROT_W-1:0]  prot_in,
  output logic [MAST_W-1:0]      master_in,
  output logic                   mastlock_in,
  output logic                   held_tran_in,
  input  logic                   active_in,
  input  logic                   readyout_in,
  input  logic                   resp_in,
  output logic [7:0]             pend_cnt
);

  localparam int c_BUNDLE_W = bmx_ctrl_w(ADDR_W, MAST_W);

  logic                  r_pend;
  logic                  r_dphase;
  logic                  w_new_tran;
  logic                  w_grant;
  logic                  w_accept;
  logic                  w_drop;
  logic                  w_load;
  logic [c_BUNDLE_W-1:0] w_live;
  logic [c_BUNDLE_W-1:0] w_held;

  // NONSEQ and SEQ both have HTRANS[1] set; IDLE/BUSY never start a transfer.
  assign w_new_tran   = HSELS & HTRANSS[1] & HREADYS;
  assign w_grant      = active_in & readyout_in;
  assign held_tran_in = r_pend | w_new_tran;
  assign w_accept     = held_tran_in & w_grant;
  assign w_drop       = r_pend & r_dphase & resp_in & readyout_in;
  assign w_load       = ~r_pend & w_new_tran & ~w_grant;

  assign w_live = {HADDRS, HAUSERS, HTRANSS, HWRITES, HSIZES, HBURSTS,
                   HPROTS, HMASTERS, HMASTLOCKS};

  bmx_in_hold_reg #(
    .WIDTH (c_BUNDLE_W)
  ) u_hold (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .load    (w_load),
    .d       (w_live),
    .q       (w_held)
  );

  assign sel_in = r_pend | HSELS;
  assign {addr_in, auser_in, trans_in, write_in, size_in, burst_in,
          prot_in, master_in, mastlock_in} = r_pend ? w_held : w_live;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_pend   <= 1'b0;
      r_dphase <= 1'b0;
    end else begin
      // An ERROR completing on the previous data phase discards the held one.
      if (w_accept || w_drop) begin
        r_pend <= 1'b0;
      end else if (w_load) begin
        r_pend <= 1'b1;
      end
      if (w_accept) begin
        r_dphase <= 1'b1;
      end else if (readyout_in) begin
        r_dphase <= 1'b0;
      end
    end
  end

  always_comb begin
    HREADYOUTS = 1'b1;
    if (r_dphase && resp_in) begin
      HREADYOUTS = readyout_in;
    end else if (r_pend) begin
      HREADYOUTS = 1'b0;
    end else if (r_dphase) begin
      HREADYOUTS = readyout_in;
    end
  end

  assign HRESPS = r_dphase ? resp_in : HRESP_OKAY;

`ifdef BMX_IN_STAGE_PEND_CNT_EN
  logic [7:0] r_pend_cnt;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_pend_cnt <= 8'h00;
    end else if (r_pend && (w_accept || w_drop)) begin
      r_pend_cnt <= 8'h00;
    end else if (r_pend && (r_pend_cnt != 8'hFF)) begin
      r_pend_cnt <= r_pend_cnt + 8'h01;
    end
  end

  assign pend_cnt = r_pend_cnt;
`else
  assign pend_cnt = 8'h00;
`endif

endmodule
`default_nettype wire

// File: doc/bmx_in_stage.md
Name: bmx_in_stage

Overview:
- Per-master input stage of the 5-master x 7-slave AHB bus matrix; one instance sits between each master port and the output stages.
- Captures the master's address/control phase. Holds it in a register when the granted output stage cannot take it this cycle.
- Presents `held_tran` plus the live or held address/control to the output stages.
- Generates the master-facing HREADYOUT/HRESP from the data-phase owner.

Parameters:
- ADDR_W, 32, address and HAUSER width
- MAST_W, 4, HMASTER width

Ports:
- HCLK input 1 AHB clock
- HRESETn input 1 async active-low reset
- HSELS input 1 master-side select (matrix-space hit)
- HADDRS, HAUSERS input ADDR_W each; master address / user address
- HTRANSS input 2 transfer type
- HWRITES/HSIZES/HBURSTS/HPROTS input 1/3/3/4 control
- HMASTERS input MAST_W; HMASTLOCKS input 1
- HREADYS input 1 master-side HREADY (bus-wide)
- HREADYOUTS output 1 ready returned to master
- HRESPS output 1 response returned to master (0 OKAY, 1 ERROR)
- sel_in output 1 select toward decoder/output stages
- addr_in, auser_in output ADDR_W each
- trans_in output 2; write_in/size_in/burst_in/prot_in output 1/3/3/4
- master_in output MAST_W; mastlock_in output 1
- held_tran_in output 1 valid transfer present (live or held)
- active_in input 1 selected output stage has granted this port this cycle
- readyout_in input 1 HREADYMUX from the output stage owning this port's data phase
- resp_in input 1 HRESP from that output stage
- pend_cnt output 8 wait counter (only with the optional feature)

Behaviour:
- `new_tran = HSELS & HTRANSS[1] & HREADYS` (NONSEQ/SEQ sampled).
- IDLE/BUSY are never held.

State:
- `pend` (reset 0): an address phase is waiting in the holding register.
- `dphase` (reset 0): this port owns a data phase in some output stage.

Holding register:
- Loads all address/control fields when `new_tran & ~(active_in & readyout_in)`.
- `pend` goes 1 on the same edge.
- Field reset values are all 0.

Output mux:
- `pend`=1: outputs come from the holding register, and `sel_in`=1.
- `pend`=0: outputs pass the live master signals.

`held_tran_in`:
- `= pend | new_tran`, combinational.

Accept:
- `accept = held_tran_in & active_in & readyout_in`.
- On accept: `pend`<=0 and `dphase`<=1.
- Otherwise, when `readyout_in`=1: `dphase`<=0.

Master-facing HREADYOUTS:
- `dphase & resp_in`: `readyout_in` (two-cycle ERROR passes through).
- else `pend`: 0.
- else `dphase`: `readyout_in`.
- else: 1.

Master-facing HRESPS:
- `= dphase ? resp_in : 0`.

Latency and ordering:
- Unheld transfer: zero added latency.
- Held transfer: address reaches the slave on the cycle `active_in`&`readyout_in` first coincide.
- A master never has more than one pending address, because HREADYOUTS=0 while `pend`=1.

Error with pending:
- When the second ERROR cycle completes (`dphase & resp_in & readyout_in`), `pend` is cleared and the held transfer is dropped. The master re-issues or cancels per AHB.

Simultaneous events:
- `new_tran` and `accept` in the same cycle with `pend`=0: the transfer is accepted directly and not loaded.
- Accept of a held transfer: the master is stalled that cycle, so no new load can coincide.

Reset mid-transfer:
- All state clears asynchronously.
- HREADYOUTS=1, HRESPS=0, held_tran_in=0.

Optional Feature:
- Macro: `BMX_IN_STAGE_PEND_CNT_EN`.
- Enabled: `pend_cnt` is an 8-bit counter.
  - Increments each cycle `pend`=1 and saturates at 255.
  - Clears to 0 on the cycle a held transfer is accepted or dropped; reset 0.
  - Feeds the performance monitor.
- Disabled: the counter logic is absent and `pend_cnt` is tied to 8'h00.

Decomposition:
- Shared package `bmx_pkg`:
  - HTRANS encodings IDLE/BUSY/NONSEQ/SEQ.
  - HRESP OKAY/ERROR.
  - ADDR_W/MAST_W defaults.
  - The addr/ctrl bundle field widths.
- One sub-module `bmx_in_hold_reg`: a load-enabled, async-reset capture register for the address/control bundle.
- The pend/dphase control and muxing stay in `bmx_in_stage`.

Test Plan:
1. Granted NONSEQ write, addr 0x2000_0010, `active_in`=1, `readyout_in`=1 -> `held_tran_in`=1 same cycle, no load, `pend`=0, HREADYOUTS follows `readyout_in` next cycle.
2. NONSEQ to 0x4000_0000 with `active_in`=0 for 3 cycles, then 1 -> HREADYOUTS=0 for 3 cycles; `addr_in`=0x4000_0000 held while HADDRS changes to 0xDEAD_BEEF; accept on cycle 4, `pend` clears.
3. INCR4 burst with `readyout_in` low 2 cycles per beat -> HREADYOUTS mirrors `readyout_in`; every SEQ beat passes with zero added latency; HRESPS=0.
4. Held NONSEQ while the previous data phase returns ERROR (`resp_in`=1, `readyout_in` 0 then 1) -> HRESPS=1 for 2 cycles, HREADYOUTS 0 then 1, `pend`=0 afterward, held transfer dropped.
5. HRESETn asserted mid-hold (`pend`=1, `dphase`=1) -> immediately HREADYOUTS=1, HRESPS=0, `held_tran_in`=0; after release, IDLE produces no `held_tran_in`.
6. With `BMX_IN_STAGE_PEND_CNT_EN`, hold 300 cycles -> `pend_cnt` saturates at 255, returns to 0 the cycle after accept; without the macro `pend_cnt`=0 throughout.
